id_operand_unit: RTL
====================

Name: id_operand_unit

Overview:
- Parametrised decode-stage operand unit: register file with NUM_RD read ports, priority forwarding from NUM_FWD downstream stages, load-use hazard detection, and a registered ID->EX operand latch.
- Next generation of the fixed two-port, three-source operand path in the ID stage.
- Sits between the instruction decoder, which supplies read addresses, and the EX pipeline register.
- Produces stallreq for the pipeline stall controller.

Parameters:
DATA_W, 32, register/operand width
ADDR_W, 5, register address width; file depth 2**ADDR_W
NUM_RD, 2, number of read ports
NUM_FWD, 3, forwarding sources; index 0 = youngest (EX), highest priority
CNT_W, 4, width of stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  squash operand latch
stall_in  in  1  hold operand latch (downstream stall)
in_valid  in  1  decoded instruction valid
rd_en  in  NUM_RD  read port i used by instruction
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
fwd_we  in  NUM_FWD  source j will write a register
fwd_waddr  in  NUM_FWD*ADDR_W  source j destination
fwd_wdata  in  NUM_FWD*DATA_W  source j result
fwd_is_load  in  NUM_FWD  source j result not yet available (load in flight)
wb_we  in  1  register file write enable
wb_waddr  in  ADDR_W  write address
wb_wdata  in  DATA_W  write data
opnd_q  out  NUM_RD*DATA_W  latched operands to EX
opnd_valid  out  1  opnd_q holds a real instruction
stallreq  out  1  combinational load-use stall request
stall_cycles  out  CNT_W  consecutive stalled cycles, saturating

Behaviour:
- Register array:
  - rst clears all entries to 0.
  - Write on posedge when wb_we && wb_waddr != 0.
  - Register 0 always reads as 0 and is never written.
- Resolved operand for port i (combinational), first rule that applies:
  - rd_addr[i] == 0 -> 0.
  - Else the lowest j with fwd_we[j] && fwd_waddr[j] == rd_addr[i] -> fwd_wdata[j].
  - Else WB bypass (see Optional Feature).
  - Else array value.
- Hazard for port i:
  - rd_en[i] && rd_addr[i] != 0, and the first matching source j has fwd_is_load[j] = 1.
  - A younger non-load match masks an older load match, so no hazard in that case.
  - stallreq = OR of port hazards, gated with in_valid.
- Operand latch (posedge), priority rst > flush > stall_in > stallreq > capture:
  - rst or flush -> opnd_q = 0, opnd_valid = 0.
  - stall_in -> hold opnd_q and opnd_valid.
  - stallreq -> bubble: opnd_q = 0, opnd_valid = 0.
  - Otherwise -> opnd_q = resolved operands, opnd_valid = in_valid.
  - Latency: one cycle from rd_addr to opnd_q.
- stall_cycles:
  - Reset value 0.
  - Increments each cycle stallreq = 1 and saturates at 2**CNT_W-1.
  - Clears to 0 in any cycle stallreq = 0.
  - Not affected by stall_in or flush.
- Reset values: opnd_q 0, opnd_valid 0, stall_cycles 0.
  - stallreq is combinational and follows its inputs during reset.
- Simultaneous WB write and read of the same address is governed by the Optional Feature.
- Reset mid-stall: latch cleared, counter cleared on the next edge.

Optional Feature:
- Macro: OPND_WB_BYPASS_EN.
- Defined:
  - A read of an address equal to wb_waddr with wb_we = 1 and no fwd match returns wb_wdata in the same cycle (write-through).
- Undefined:
  - That case does not bypass; the array value is used.
  - The port raises a hazard (stallreq = 1) for that cycle, so the instruction re-reads after the write lands.

Test Plan:
- Reset, then wb write r5 = 0x1234_5678; next cycle read port0 = r5 with no fwd -> opnd_q[port0] = 0x1234_5678, opnd_valid = 1.
- fwd_we = 3'b111 to r7 with data A/B/C for EX/MEM/WB sources, read r7 -> operand = A; drop fwd_we[0] -> operand = B.
- EX source (j = 0) is a load to r3, port1 reads r3 with rd_en = 1 -> stallreq = 1, next opnd_valid = 0, opnd_q = 0; hold 20 cycles -> stall_cycles saturates at 15; clear load -> counter 0, operand captured.
- Read r0 while fwd_we[0] targets r0 with data 0xFFFF_FFFF -> operand = 0, no stall.
- stall_in = 1 with changing inputs -> opnd_q unchanged; flush = 1 with stall_in = 1 -> opnd_q = 0, opnd_valid = 0.
- Same-cycle wb write r9 = 0xABCD and read r9 -> with macro: operand 0xABCD, stallreq = 0; without macro: stallreq = 1, then 0xABCD the following cycle.

Source files
------------

// File: rtl/id_operand_unit.sv
// id_operand_unit: decode-stage register file, priority forwarding, load-use hazard detect, ID->EX operand latch.
// Latency: operands resolve combinationally; opnd_q/opnd_valid are registered one cycle after rd_addr.
// Backpressure: stall_in holds the latch; stallreq is raised combinationally on a load-use hazard and inserts a bubble.
//
// Optional feature macro: OPND_WB_BYPASS_EN
//   defined   -> a read matching an in-progress WB write (and no forward match) returns wb_wdata directly
//   undefined -> such a read takes the array value and raises a hazard so it re-reads after the write lands
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   flush, stall_in          squash / hold the operand latch
//   in_valid, rd_en, rd_addr decoded instruction and its read ports (port i at [i*ADDR_W +: ADDR_W])
//   fwd_*                    NUM_FWD forwarding sources, index 0 youngest and highest priority
//   wb_*                     register file write port
//   opnd_q, opnd_valid       latched operands to EX
//   stallreq, stall_cycles   load-use stall request and saturating stalled-cycle count
module id_operand_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      stall_in,
  input  logic                      in_valid,
  input  logic [NUM_RD-1:0]         rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic                      wb_we,
  input  logic [ADDR_W-1:0]         wb_waddr,
  input  logic [DATA_W-1:0]         wb_wdata,
  output logic [NUM_RD*DATA_W-1:0]  opnd_q,
  output logic                      opnd_valid,
  output logic                      stallreq,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0]        rf_q [DEPTH];
  logic [NUM_RD*DATA_W-1:0] opnd_d;
  logic                     opnd_valid_q;
  logic                     opnd_valid_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;

  logic [ADDR_W-1:0] port_addr [NUM_RD];
  logic [DATA_W-1:0] port_val  [NUM_RD];
  logic              fwd_hit   [NUM_RD];
  logic              fwd_load  [NUM_RD];
  logic              wb_hit    [NUM_RD];
  logic [NUM_RD-1:0] port_haz;

  // Register array; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        rf_q[k] <= '0;
      end
    end else if (wb_we && (wb_waddr != '0)) begin
      rf_q[wb_waddr] <= wb_wdata;
    end
  end

  // Operand resolution and per-port hazard.
  always_comb begin
    port_haz = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      port_addr[i] = rd_addr[i*ADDR_W +: ADDR_W];
      port_val[i]  = rf_q[port_addr[i]];
      fwd_hit[i]   = 1'b0;
      fwd_load[i]  = 1'b0;
      wb_hit[i]    = wb_we && (wb_waddr == port_addr[i]);
`ifdef OPND_WB_BYPASS_EN
      if (wb_hit[i]) begin
        port_val[i] = wb_wdata;
      end
`endif
      // Walk oldest to youngest so the lowest matching index wins, and
      // its load flag alone decides the hazard (younger non-load masks older load).
      for (int j = NUM_FWD - 1; j >= 0; j--) begin
        if (fwd_we[j] && (fwd_waddr[j*ADDR_W +: ADDR_W] == port_addr[i])) begin
          fwd_hit[i]  = 1'b1;
          fwd_load[i] = fwd_is_load[j];
          port_val[i] = fwd_wdata[j*DATA_W +: DATA_W];
        end
      end
      if (port_addr[i] == '0) begin
        port_val[i] = '0;
      end
`ifdef OPND_WB_BYPASS_EN
      port_haz[i] = rd_en[i] && (port_addr[i] != '0) && fwd_hit[i] && fwd_load[i];
`else
      // Without write-through, a same-cycle WB to the read address must be re-read next cycle.
      port_haz[i] = rd_en[i] && (port_addr[i] != '0) &&
                    (fwd_hit[i] ? fwd_load[i] : wb_hit[i]);
`endif
    end
  end

  assign stallreq = in_valid && (|port_haz);

  // Latch next-state: rst > flush > stall_in > stallreq bubble > capture.
  always_comb begin
    opnd_d       = opnd_q;
    opnd_valid_d = opnd_valid_q;
    if (flush) begin
      opnd_d       = '0;
      opnd_valid_d = 1'b0;
    end else if (stall_in) begin
      opnd_d       = opnd_q;
      opnd_valid_d = opnd_valid_q;
    end else if (stallreq) begin
      opnd_d       = '0;
      opnd_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        opnd_d[i*DATA_W +: DATA_W] = port_val[i];
      end
      opnd_valid_d = in_valid;
    end
  end

  // Stall counter tracks stallreq only; flush and stall_in do not touch it.
  always_comb begin
    cnt_d = '0;
    if (stallreq) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_q       <= '0;
      opnd_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      opnd_q       <= opnd_d;
      opnd_valid_q <= opnd_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign opnd_valid   = opnd_valid_q;
  assign stall_cycles = cnt_q;

endmodule
